// File: rtl/clock_divider_gen.sv
// ---------------------------------------------------------------------------
// clock_divider_gen
//
// Multi-channel, runtime-programmable clock divider. Each of NUM_CH channels
// produces a registered divided clock from clk, can be started and stopped
// without runt pulses, and accepts a new divide ratio through a valid/ready
// handshake. The new ratio takes effect at the next period boundary.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous reset, active-high
//   cfg_valid  config request
//   cfg_ready  config accepted when cfg_valid && cfg_ready
//   cfg_ch     target channel of the config request
//   cfg_div    new divide ratio N (0 and 1 are stored as 2)
//   en         per-channel run enable
//   clk_out    per-channel divided clock (registered)
//   tick       one-cycle pulse in the cycle clk_out rises
//   stopped    channel idle, clk_out held low
// ---------------------------------------------------------------------------
module clock_divider_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] stopped
);

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RUNNING  = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] pending;
  logic [DIV_W-1:0]  cfg_div_fix;

  // Ratios below 2 cannot produce a high and a low phase, so clamp to 2.
  assign cfg_div_fix = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

  // Requests to a non-existent channel are always "accepted" and dropped.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // latch can be inferred on an unlisted path.
  always_comb begin
    cfg_ready = 1'b1;
    if (32'(cfg_ch) < NUM_CH) cfg_ready = !pending[cfg_ch];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             stop_q;

    logic [DIV_W-1:0] high_len;
    logic             wrap;
    logic [DIV_W-1:0] cnt_nxt;
    logic             high_now;
    logic             accept;

    assign high_len = div >> 1;
    assign wrap     = (cnt == div - DIV_W'(1));
    assign cnt_nxt  = wrap ? '0 : cnt + DIV_W'(1);
    assign high_now = (cnt < high_len);
    // pend_q low implies cfg_ready is high for this channel.
    assign accept   = cfg_valid && (cfg_ch == CH_W'(g)) && !pend_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values; later assignments in the block
    // deliberately override earlier ones within the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= ST_STOPPED;
        cnt    <= '0;
        div    <= DEF_DIV;
        shadow <= DEF_DIV;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        stop_q <= 1'b1;
      end else begin
        tick_q <= 1'b0;

        if (accept) begin
          pend_q <= 1'b1;
          shadow <= cfg_div_fix;
        end

        case (state)
          ST_STOPPED: begin
            // Load before (or together with) a start so the first period
            // already uses the new ratio.
            if (pend_q) begin
              div    <= shadow;
              pend_q <= 1'b0;
            end
            if (en[g]) begin
              state  <= ST_RUNNING;
              cnt    <= '0;
              clk_q  <= 1'b1;
              tick_q <= 1'b1;
              stop_q <= 1'b0;
            end
          end

          default: begin
            if (!en[g] && !high_now) begin
              // Disabled during the low phase: stop at once, output is low.
              state  <= ST_STOPPED;
              cnt    <= '0;
              clk_q  <= 1'b0;
              stop_q <= 1'b1;
            end else begin
              cnt    <= cnt_nxt;
              clk_q  <= (cnt_nxt < high_len);
              tick_q <= wrap;
              if (wrap && pend_q) begin
                div    <= shadow;
                pend_q <= 1'b0;
              end
              if (en[g]) begin
                // Also cancels a stop in progress without a phase change.
                state <= ST_RUNNING;
              end else if (cnt_nxt < high_len) begin
                state <= ST_STOPPING;
              end else begin
                // High phase completed this cycle.
                state  <= ST_STOPPED;
                cnt    <= '0;
                stop_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end

    assign pending[g] = pend_q;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign stopped[g] = stop_q;
  end

endmodule

// File: tb/tb_clock_divider_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_gen
//
// Self-checking bench for clock_divider_gen with three channels (so that an
// out-of-range cfg_ch is expressible). Expected high/low phase lengths are
// pushed onto a scoreboard queue when a channel is configured or started and
// popped when a full period of clk_out has been measured. Outputs are sampled
// on the falling edge; inputs are driven on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_clock_divider_gen;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] stopped;

  clock_divider_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .en        (en),
    .clk_out   (clk_out),
    .tick      (tick),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIV_W-1:0] div;
    int               hi;
    int               lo;
  } vec_t;

  typedef struct {
    int hi;
    int lo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Precondition: current sample is the first high cycle of a period.
  // Returns at the first high sample of the following period.
  task automatic measure(input int ch, output int hi, output int lo, output int tk);
    hi = 0; lo = 0; tk = 0;
    while (clk_out[ch] && hi < 600) begin
      hi++;
      if (tick[ch]) tk++;
      @(negedge clk);
    end
    while (!clk_out[ch] && lo < 600) begin
      lo++;
      if (tick[ch]) tk++;
      @(negedge clk);
    end
  endtask

  task automatic score(input string name, input int ch);
    int hi, lo, tk;
    exp_t e;
    measure(ch, hi, lo, tk);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
      check({name, "_ticks"}, tk, 1);
    end
  endtask

  task automatic wait_stopped(input int ch);
    int n = 0;
    while (!stopped[ch] && n < 600) begin
      n++;
      @(negedge clk);
    end
    check("stop_wait", 32'(stopped[ch]), 1);
  endtask

  // 16-sample window starting at a rise sample; en[ch] is dropped at
  // sample off_at and re-asserted at sample on_at (negative = never).
  task automatic window(input int ch, input int off_at, input int on_at,
                        output int hi, output int first_lo);
    hi = 0; first_lo = -1;
    for (int i = 0; i < 16; i++) begin
      if (i == off_at) en[ch] = 1'b0;
      if (i == on_at)  en[ch] = 1'b1;
      if (clk_out[ch]) hi++;
      else if (first_lo < 0) first_lo = i;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   hi, first_lo, n, rlo;

    vecs[0] = '{8'd16,  8,   8};
    vecs[1] = '{8'd5,   2,   3};
    vecs[2] = '{8'd0,   1,   1};
    vecs[3] = '{8'd1,   1,   1};
    vecs[4] = '{8'd2,   1,   1};
    vecs[5] = '{8'd3,   1,   2};
    vecs[6] = '{8'd255, 127, 128};
    vecs[7] = '{8'd7,   3,   4};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; en = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick",    32'(tick), 0);
    check("rst_stopped", 32'(stopped), 32'b111);
    check("rst_ready",   32'(cfg_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: default N=16 on ch0, first rise one clock after en.
    en[0] = 1'b1;
    @(negedge clk);
    check("t1_rise",    32'(clk_out), 32'b001);
    check("t1_tick",    32'(tick[0]), 1);
    check("t1_stopped", 32'(stopped), 32'b110);
    sb.push_back('{8, 8});
    sb.push_back('{8, 8});
    score("t1_p0", 0);
    score("t1_p1", 0);

    // Test 3: drop en two cycles into the high phase.
    window(0, 2, -1, hi, first_lo);
    check("t3_hi",       hi, 8);
    check("t3_first_lo", first_lo, 8);
    check("t3_clk_out",  32'(clk_out[0]), 0);
    check("t3_stopped",  32'(stopped[0]), 1);

    // Test 4: restart, then toggle en off/on inside STOPPING.
    en[0] = 1'b1;
    @(negedge clk);
    check("t4_rise", 32'(clk_out[0]), 1);
    window(0, 2, 4, hi, first_lo);
    check("t4_hi",       hi, 8);
    check("t4_first_lo", first_lo, 8);
    check("t4_rise2",    32'(clk_out[0]), 1);
    check("t4_tick2",    32'(tick[0]), 1);
    sb.push_back('{8, 8});
    score("t4_p", 0);

    // Table: program stopped ch1 and start it in the same cycle the ratio
    // loads; the new ratio must apply from the first period.
    foreach (vecs[i]) begin
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = vecs[i].div;
      check("tbl_ready", 32'(cfg_ready), 1);
      sb.push_back('{vecs[i].hi, vecs[i].lo});
      @(negedge clk);
      cfg_valid = 1'b0; en[1] = 1'b1;
      check("tbl_pending", 32'(cfg_ready), 0);
      @(negedge clk);
      check("tbl_rise", 32'(clk_out[1]), 1);
      check("tbl_tick", 32'(tick[1]), 1);
      score("tbl", 1);
      check("tbl_ready_after", 32'(cfg_ready), 1);
      en[1] = 1'b0;
      wait_stopped(1);
    end

    // Test 2: reprogram ch1 N=16 -> N=5 while running.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd16;
    @(negedge clk);
    cfg_valid = 1'b0; en[1] = 1'b1;
    @(negedge clk);
    check("t2_rise", 32'(clk_out[1]), 1);
    sb.push_back('{8, 8});
    score("t2_old", 1);
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1; cfg_div = 8'd5;
    check("t2_ready", 32'(cfg_ready), 1);
    n = 0; rlo = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) cfg_valid = 1'b0;
      if (!cfg_ready) rlo++;
    end while (!tick[1] && n < 40);
    check("t2_wrap_cycles", n, 13);
    check("t2_ready_low",   rlo, 12);
    check("t2_ready_back",  32'(cfg_ready), 1);
    sb.push_back('{2, 3});
    sb.push_back('{2, 3});
    score("t2_new0", 1);
    score("t2_new1", 1);

    // Test 5: out-of-range channel is ignored and never blocks.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
    check("t5_ready_oor", 32'(cfg_ready), 1);
    @(negedge clk);
    check("t5_ready_oor2", 32'(cfg_ready), 1);
    cfg_valid = 1'b0; cfg_ch = 2'd2;
    check("t5_ready_ch2", 32'(cfg_ready), 1);
    en[2] = 1'b1;
    @(negedge clk);
    check("t5_rise", 32'(clk_out[2]), 1);
    sb.push_back('{8, 8});
    score("t5_ch2", 2);

    // Test 6: reset in the middle of a high phase on all channels.
    en = '0;
    wait_stopped(0);
    wait_stopped(1);
    wait_stopped(2);
    en = 3'b111;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_high", 32'(clk_out), 32'b111);
    #2 rst = 1'b1;
    #1;
    check("t6_clk_out", 32'(clk_out), 0);
    check("t6_tick",    32'(tick), 0);
    check("t6_stopped", 32'(stopped), 32'b111);
    check("t6_ready",   32'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rise", 32'(clk_out), 32'b111);
    check("t6_tick_all", 32'(tick), 32'b111);
    sb.push_back('{8, 8});
    score("t6_ch0", 0);
    check("t6_ch1_default", 32'(tick[1]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
